// File: rtl/hls_fast_corner_mul_pkg.sv
// hls_fast_corner_mul_pkg: default widths, product-width helper and the pipeline stage record.
package hls_fast_corner_mul_pkg;
   localparam int DIN0_WIDTH_DEF = 8;
   localparam int DIN1_WIDTH_DEF = 22;
   localparam int DOUT_WIDTH_DEF = 29;
   localparam int NUM_STAGE_DEF = 3;
   localparam int STAGE_DW = 64;
   typedef struct packed {
      logic valid;
      logic sgn;
      logic [STAGE_DW-1:0] data;
   } stage_t;
   function automatic int prod_width(input int a, input int b);
      return a + b;
   endfunction
endpackage

// File: rtl/hls_fast_corner_mul_pipe_if.sv
// hls_fast_corner_mul_pipe_if: operand/result valid-ready bus of the FAST multiplier pipe.
interface hls_fast_corner_mul_pipe_if
   import hls_fast_corner_mul_pkg::*;
#(
   parameter int DIN0_WIDTH = DIN0_WIDTH_DEF,
   parameter int DIN1_WIDTH = DIN1_WIDTH_DEF,
   parameter int DOUT_WIDTH = DOUT_WIDTH_DEF
) ();
   logic in_valid;
   logic in_ready;
   logic in_signed;
   logic [DIN0_WIDTH-1:0] din0;
   logic [DIN1_WIDTH-1:0] din1;
   logic out_valid;
   logic out_ready;
   logic [DOUT_WIDTH-1:0] dout;
   logic out_ovf;
   modport slave (
      input in_valid, in_signed, din0, din1, out_ready,
      output in_ready, out_valid, dout, out_ovf
   );
   modport master (
      output in_valid, in_signed, din0, din1, out_ready,
      input in_ready, out_valid, dout, out_ovf
   );
endinterface

// File: rtl/hls_fast_corner_mul_core.sv
// hls_fast_corner_mul_core: extend-multiply and clamp/truncate datapath.
// FAST_MUL_SAT_EN selects saturation with overflow flag; otherwise results wrap.
module hls_fast_corner_mul_core
   import hls_fast_corner_mul_pkg::*;
#(
   parameter int DIN0_WIDTH = DIN0_WIDTH_DEF,
   parameter int DIN1_WIDTH = DIN1_WIDTH_DEF,
   parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
   localparam int P = prod_width(DIN0_WIDTH, DIN1_WIDTH)
) (
   input  logic mul_sgn,
   input  logic [DIN0_WIDTH-1:0] a,
   input  logic [DIN1_WIDTH-1:0] b,
   output logic [P-1:0] prod,
   input  logic clamp_sgn,
   input  logic [P-1:0] full,
   output logic [DOUT_WIDTH-1:0] res,
   output logic ovf
);
   logic [P-1:0] a_ext, b_ext;
   assign a_ext = {{DIN1_WIDTH{a[DIN0_WIDTH-1] & mul_sgn}}, a};
   assign b_ext = {{DIN0_WIDTH{b[DIN1_WIDTH-1] & mul_sgn}}, b};
   assign prod = a_ext * b_ext;
`ifdef FAST_MUL_SAT_EN
   logic ovf_u, ovf_s;
   logic [DOUT_WIDTH-1:0] smax;
   if (DOUT_WIDTH < P) begin : g_ovf
      assign ovf_u = |full[P-1:DOUT_WIDTH];
      assign ovf_s = full[P-1:DOUT_WIDTH-1] != {(P-DOUT_WIDTH+1){full[P-1]}};
   end else begin : g_fit
      assign ovf_u = 1'b0;
      assign ovf_s = 1'b0;
   end
   assign smax = {DOUT_WIDTH{1'b1}} >> 1;
   assign ovf = clamp_sgn ? ovf_s : ovf_u;
   assign res = !ovf ? full[DOUT_WIDTH-1:0] : !clamp_sgn ? '1 : full[P-1] ? ~smax : smax;
`else
   logic unused_clamp;
   assign unused_clamp = ^{clamp_sgn, full};
   assign ovf = 1'b0;
   assign res = full[DOUT_WIDTH-1:0];
`endif
endmodule

// File: rtl/hls_fast_corner_mul_pipe.sv
// hls_fast_corner_mul_pipe: NUM_STAGE-deep valid/ready multiplier pipe for FAST scoring.
// Saturation is built only when FAST_MUL_SAT_EN is defined.
module hls_fast_corner_mul_pipe
   import hls_fast_corner_mul_pkg::*;
#(
   parameter int DIN0_WIDTH = DIN0_WIDTH_DEF,
   parameter int DIN1_WIDTH = DIN1_WIDTH_DEF,
   parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
   parameter int NUM_STAGE = NUM_STAGE_DEF
) (
   input logic ap_clk,
   input logic ap_rst,
   hls_fast_corner_mul_pipe_if.slave bus
);
   localparam int P = prod_width(DIN0_WIDTH, DIN1_WIDTH);
   stage_t s [NUM_STAGE];
   logic [STAGE_DW-1:0] nd [NUM_STAGE];
   logic adv, m_sgn, c_sgn, c_ovf;
   logic [DIN0_WIDTH-1:0] m_a;
   logic [DIN1_WIDTH-1:0] m_b;
   logic [P-1:0] m_p, c_p;
   logic [DOUT_WIDTH-1:0] c_d;

   assign adv = !s[NUM_STAGE-1].valid || bus.out_ready;
   assign bus.in_ready = adv && !ap_rst;
   assign bus.out_valid = s[NUM_STAGE-1].valid;
   assign bus.dout = s[NUM_STAGE-1].data[DOUT_WIDTH-1:0];
   assign bus.out_ovf = s[NUM_STAGE-1].data[DOUT_WIDTH];

   hls_fast_corner_mul_core #(
      .DIN0_WIDTH(DIN0_WIDTH), .DIN1_WIDTH(DIN1_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)
   ) u_core (
      .mul_sgn(m_sgn), .a(m_a), .b(m_b), .prod(m_p),
      .clamp_sgn(c_sgn), .full(c_p), .res(c_d), .ovf(c_ovf)
   );

   // Last stage holds {ovf, dout}; stage 0 holds operands unless it is also the last.
   if (NUM_STAGE == 1) begin : g_one
      assign m_sgn = bus.in_signed;
      assign m_a = bus.din0;
      assign m_b = bus.din1;
      assign c_sgn = bus.in_signed;
      assign c_p = m_p;
      assign nd[0] = STAGE_DW'({c_ovf, c_d});
   end else begin : g_multi
      assign m_sgn = s[0].sgn;
      assign m_a = s[0].data[P-1:DIN1_WIDTH];
      assign m_b = s[0].data[DIN1_WIDTH-1:0];
      assign c_sgn = s[NUM_STAGE-2].sgn;
      assign c_p = NUM_STAGE == 2 ? m_p : s[NUM_STAGE-2].data[P-1:0];
      assign nd[0] = STAGE_DW'({bus.din0, bus.din1});
      for (genvar i = 1; i < NUM_STAGE; i++) begin : g_nd
         assign nd[i] = i == NUM_STAGE-1 ? STAGE_DW'({c_ovf, c_d})
                      : i == 1 ? STAGE_DW'(m_p) : s[i-1].data;
      end
   end

   for (genvar i = 0; i < NUM_STAGE; i++) begin : g_unused
      logic unused_rec;
      assign unused_rec = ^{s[i].sgn, s[i].data};
   end

   always_ff @(posedge ap_clk)
      if (ap_rst)
         for (int k = 0; k < NUM_STAGE; k++) s[k] <= '0;
      else if (adv) begin
         s[0] <= '{valid: bus.in_valid, sgn: bus.in_signed, data: nd[0]};
         for (int k = 1; k < NUM_STAGE; k++)
            s[k] <= '{valid: s[k-1].valid, sgn: s[k-1].sgn, data: nd[k]};
      end
endmodule

// File: doc/hls_fast_corner_mul_pipe.md
# hls_fast_corner_mul_pipe

Parametrised, pipelined multiplier with a valid/ready handshake for the FAST corner-detection datapath. It replaces fixed-width combinational products, such as 8-bit pixel by 22-bit coefficient, in score and threshold arithmetic. Each transaction selects signed or unsigned operation. The block can optionally saturate results that exceed the output width.

## Interface
- DIN0_WIDTH, 8, width of operand a (pixel side)
- DIN1_WIDTH, 22, width of operand b (coefficient side)
- DOUT_WIDTH, 29, result width; any value 1..DIN0_WIDTH+DIN1_WIDTH is legal
- NUM_STAGE, 3, register stages from input acceptance to output; minimum 1
- ap_clk  in  1  clock; all logic is on the rising edge
- ap_rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts the beat this cycle
- in_signed  in  1  1: both operands are two's complement; 0: both are unsigned
- din0  in  DIN0_WIDTH  operand a
- din1  in  DIN1_WIDTH  operand b
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- dout  out  DOUT_WIDTH  product
- out_ovf  out  1  full product did not fit in DOUT_WIDTH

## Operation
- Full product width is P = DIN0_WIDTH+DIN1_WIDTH. Operands are sign- or zero-extended to P according to in_signed, then multiplied exactly.
- Pipeline advance: adv = !out_valid || out_ready.
  - in_ready = adv && !ap_rst.
  - A beat is accepted when in_valid && in_ready.
- When adv is high, every stage shifts by one. Each stage register holds {valid, signed, data}. Stage 0 captures valid = in_valid.
- When adv is low, all stages hold. Bubbles are not collapsed.
- The output stage drives out_valid, dout and out_ovf. These signals stay stable while out_valid && !out_ready.
- Overflow test, applied to the full product:
  - Unsigned: product ≥ 2^DOUT_WIDTH.
  - Signed: product is outside [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
- When DOUT_WIDTH = P, overflow is impossible and out_ovf is always 0.
- Stage split:
  - Stage 0 registers the operands.
  - The product is formed in stage 0, or stage 1 if NUM_STAGE > 1.
  - Clamp/truncate logic sits in the last stage.
  - Extra stages are pure delay, available for DSP retiming.

## Timing
- Reset (ap_rst high at a clock edge): all stage valid bits clear; out_valid = 0, dout = 0, out_ovf = 0. in_ready is 0 while ap_rst is high and 1 on the first cycle after.
- Latency: a beat accepted at edge k appears with out_valid = 1 after edge k+NUM_STAGE-1, i.e. NUM_STAGE cycles with no stall.
- Throughput is 1 beat per cycle while out_ready stays high.
- Stall: out_valid && !out_ready freezes the whole pipeline, and in_ready drops in the same cycle (combinational from out_ready). No beat is lost or duplicated.
- Simultaneous output handshake and input acceptance is legal; the pipeline shifts once.
- Reset mid-operation discards all in-flight beats. No result is produced for them.
- in_signed is sampled with its beat and travels with it. Mixed modes back-to-back are legal.

## Configuration
- FAST_MUL_SAT_EN defined:
  - On overflow, dout clamps to the range bound (unsigned max 2^DOUT_WIDTH-1; signed max or min by sign of the product).
  - out_ovf = 1 on overflow.
- FAST_MUL_SAT_EN undefined:
  - dout = low DOUT_WIDTH bits of the product (wrap).
  - out_ovf is tied 0.
  - Clamp logic is not synthesised.

## Structure
- Package hls_fast_corner_mul_pkg holds:
  - default width constants;
  - the function computing P;
  - the stage-record typedef {valid, signed, data}.
- Sub-module hls_fast_corner_mul_core: combinational extend-multiply-clamp, instanced inside the pipeline wrapper. It receives FAST_MUL_SAT_EN through the same define.

## Test plan
- Defaults, unsigned, din0=12, din1=1000, out_ready=1: dout=12000, out_ovf=0, out_valid exactly 3 cycles after acceptance.
- Unsigned din0=255, din1=4194303:
  - with FAST_MUL_SAT_EN: dout=536870911, out_ovf=1;
  - without it: dout=532676353, out_ovf=0.
- Signed din0=0xFF (-1), din1=2: dout=0x1FFFFFFE (-2), out_ovf=0.
- Stream of 10 beats, out_ready low for 4 cycles mid-stream: in_ready falls in the same cycle; dout/out_valid hold; all 10 products arrive in order, with no loss or duplicates.
- ap_rst asserted for 1 cycle with 3 beats in flight: out_valid=0, dout=0 the next cycle; none of those 3 beats emerge; a new beat after reset returns after 3 cycles.
- NUM_STAGE=1, DOUT_WIDTH=30: back-to-back alternating signed/unsigned beats; each result is correct for its own mode; out_ovf is never set.
